// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the unified-memory arbiter.
// The master modport is the arbiter's view; slave is the pipeline plus memory.
interface mem_port_arbiter_if #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
);
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [2:0]        d_funct3;
  logic [XLEN-1:0]   d_rdata;
  logic              d_valid;
  logic              d_misalign;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              stall_f;
  logic              stall_m;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, d_misalign,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output stall_f, stall_m
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, d_misalign,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  stall_f, stall_m
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store unit.
// Data has priority; one transaction in flight; misaligned data accesses never reach memory.
module mem_port_arbiter #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [XLEN-1:0] DW_MASK = {{(XLEN-3){1'b1}}, 3'b000};

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      2'b10:   m = (a[1:0] != 2'b00);
      2'b11:   m = (a != 3'b000);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [STRB_W-1:0] byte_strobe(input logic [1:0] size, input logic [2:0] a);
    logic [7:0] s;
    case (size)
      2'b00:   s = 8'h01 << a;
      2'b01:   s = 8'h03 << a;
      2'b10:   s = 8'h0F << a;
      2'b11:   s = 8'hFF;
      default: s = 8'h00;
    endcase
    return STRB_W'(s);
  endfunction

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              wsel_q, wsel_d;
  logic              mem_req_q, mem_req_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              d_misalign_q, d_misalign_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;

  logic [2:0]        d_off_s;
  logic [5:0]        d_shift_s;

  assign d_off_s   = bus.d_addr[2:0];
  assign d_shift_s = {d_off_s, 3'b000};

  // Next-state and next-register computation for the request/issue/wait/done sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    strb_d       = strb_q;
    wdata_d      = wdata_q;
    wsel_d       = wsel_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_req_d    = 1'b0;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    d_misalign_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.d_req) begin
          owner_d = OWN_D;
          if (is_misaligned(bus.d_funct3[1:0], d_off_s)) begin
            state_d      = ST_DONE;
            d_rdata_d    = '0;
            d_valid_d    = 1'b1;
            d_misalign_d = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            addr_d    = bus.d_addr & DW_MASK;
            we_d      = bus.d_we;
            strb_d    = bus.d_we ? byte_strobe(bus.d_funct3[1:0], d_off_s) : '0;
            wdata_d   = bus.d_wdata << d_shift_s;
            mem_req_d = 1'b1;
          end
        end else if (bus.if_req) begin
          state_d   = ST_ISSUE;
          owner_d   = OWN_I;
          addr_d    = bus.if_addr & DW_MASK;
          we_d      = 1'b0;
          strb_d    = '0;
          wdata_d   = '0;
          wsel_d    = bus.if_addr[2];
          mem_req_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = ST_DONE;
          if (owner_q == OWN_I) begin
            if_rdata_d = wsel_q ? bus.mem_rdata[XLEN-1 -: 32] : bus.mem_rdata[31:0];
            if_valid_d = 1'b1;
          end else begin
            d_rdata_d = bus.mem_rdata;
            d_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      strb_q       <= '0;
      wdata_q      <= '0;
      wsel_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      d_misalign_q <= 1'b0;
      if_rdata_q   <= 32'h0000_0000;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      strb_q       <= strb_d;
      wdata_q      <= wdata_d;
      wsel_q       <= wsel_d;
      mem_req_q    <= mem_req_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      d_misalign_q <= d_misalign_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wstrb  = strb_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.d_misalign = d_misalign_q;

  // Stalls must drop in the same cycle as the completion pulse.
  assign bus.stall_f = bus.if_req & ~if_valid_q;
  assign bus.stall_m = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, store lanes, misalign, grant wait, reset abort.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fails;

  mem_port_arbiter_if #(.XLEN(64)) bus ();

  mem_port_arbiter #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fails   = 0;
    reset          = 1'b1;
    bus.if_req     = 1'b0;
    bus.if_addr    = 64'h0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = 64'h0;
    bus.d_wdata    = 64'h0;
    bus.d_funct3   = 3'b000;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 64'h0;
    tick();
    tick();

    // Reset state
    chk("rst_mem_req",    64'(bus.mem_req),    64'd0);
    chk("rst_mem_we",     64'(bus.mem_we),     64'd0);
    chk("rst_mem_wstrb",  64'(bus.mem_wstrb),  64'd0);
    chk("rst_mem_addr",   bus.mem_addr,        64'd0);
    chk("rst_if_valid",   64'(bus.if_valid),   64'd0);
    chk("rst_d_valid",    64'(bus.d_valid),    64'd0);
    chk("rst_d_misalign", 64'(bus.d_misalign), 64'd0);
    chk("rst_d_rdata",    bus.d_rdata,         64'd0);
    reset = 1'b0;

    // T1: fetch at 0x1004, zero wait states
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h1004;
    #1;
    chk("t1_stall_f_c0", 64'(bus.stall_f), 64'd1);
    tick();
    chk("t1_mem_req_c1",  64'(bus.mem_req), 64'd1);
    chk("t1_mem_addr_c1", bus.mem_addr,     64'h1000);
    chk("t1_mem_we_c1",   64'(bus.mem_we),  64'd0);
    chk("t1_stall_f_c1",  64'(bus.stall_f), 64'd1);
    bus.mem_gnt = 1'b1;
    tick();
    chk("t1_mem_req_c2",  64'(bus.mem_req),  64'd0);
    chk("t1_if_valid_c2", 64'(bus.if_valid), 64'd0);
    chk("t1_stall_f_c2",  64'(bus.stall_f),  64'd1);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    chk("t1_if_valid_c3", 64'(bus.if_valid), 64'd1);
    chk("t1_if_rdata_c3", 64'(bus.if_rdata), 64'hAAAA_BBBB);
    chk("t1_stall_f_c3",  64'(bus.stall_f),  64'd0);
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b0;
    tick();
    chk("t1_if_valid_c4", 64'(bus.if_valid), 64'd0);

    // T2: simultaneous load D at 0x2000 and fetch at 0x1000; data first
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_funct3 = 3'b011;
    bus.d_addr   = 64'h2000;
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h1000;
    #1;
    chk("t2_stall_f_c0", 64'(bus.stall_f), 64'd1);
    chk("t2_stall_m_c0", 64'(bus.stall_m), 64'd1);
    tick();
    chk("t2_mem_req_c1",   64'(bus.mem_req),   64'd1);
    chk("t2_mem_addr_c1",  bus.mem_addr,       64'h2000);
    chk("t2_mem_wstrb_c1", 64'(bus.mem_wstrb), 64'd0);
    chk("t2_stall_f_c1",   64'(bus.stall_f),   64'd1);
    bus.mem_gnt = 1'b1;
    tick();
    chk("t2_stall_f_c2", 64'(bus.stall_f), 64'd1);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h1122_3344_5566_7788;
    tick();
    chk("t2_d_valid_c3",  64'(bus.d_valid),  64'd1);
    chk("t2_d_rdata_c3",  bus.d_rdata,       64'h1122_3344_5566_7788);
    chk("t2_if_valid_c3", 64'(bus.if_valid), 64'd0);
    chk("t2_stall_m_c3",  64'(bus.stall_m),  64'd0);
    chk("t2_stall_f_c3",  64'(bus.stall_f),  64'd1);
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    tick();
    chk("t2_mem_req_c4", 64'(bus.mem_req), 64'd0);
    chk("t2_stall_f_c4", 64'(bus.stall_f), 64'd1);
    tick();
    chk("t2_mem_req_c5",  64'(bus.mem_req), 64'd1);
    chk("t2_mem_addr_c5", bus.mem_addr,     64'h1000);
    bus.mem_gnt = 1'b1;
    tick();
    chk("t2_stall_f_c6", 64'(bus.stall_f), 64'd1);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    chk("t2_if_valid_c7", 64'(bus.if_valid), 64'd1);
    chk("t2_if_rdata_c7", 64'(bus.if_rdata), 64'hCAFE_F00D);
    chk("t2_stall_f_c7",  64'(bus.stall_f),  64'd0);
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b0;
    tick();

    // T3: store byte at 0x3005, ack delayed one extra cycle
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_funct3 = 3'b000;
    bus.d_addr   = 64'h3005;
    bus.d_wdata  = 64'h5A;
    tick();
    chk("t3_mem_req",   64'(bus.mem_req),   64'd1);
    chk("t3_mem_we",    64'(bus.mem_we),    64'd1);
    chk("t3_mem_addr",  bus.mem_addr,       64'h3000);
    chk("t3_mem_wstrb", 64'(bus.mem_wstrb), 64'h20);
    chk("t3_mem_wdata", bus.mem_wdata,      64'h0000_5A00_0000_0000);
    bus.mem_gnt = 1'b1;
    tick();
    chk("t3_d_valid_c2", 64'(bus.d_valid), 64'd0);
    bus.mem_gnt = 1'b0;
    tick();
    chk("t3_d_valid_c3", 64'(bus.d_valid), 64'd0);
    chk("t3_stall_m_c3", 64'(bus.stall_m), 64'd1);
    bus.mem_rvalid = 1'b1;
    tick();
    chk("t3_d_valid_c4", 64'(bus.d_valid), 64'd1);
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    tick();
    chk("t3_d_valid_c5", 64'(bus.d_valid), 64'd0);

    // T4: misaligned load word at 0x4002
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_funct3 = 3'b010;
    bus.d_addr   = 64'h4002;
    tick();
    chk("t4_d_valid",    64'(bus.d_valid),    64'd1);
    chk("t4_d_misalign", 64'(bus.d_misalign), 64'd1);
    chk("t4_d_rdata",    bus.d_rdata,         64'd0);
    chk("t4_mem_req_c1", 64'(bus.mem_req),    64'd0);
    bus.d_req = 1'b0;
    tick();
    chk("t4_d_misalign_c2", 64'(bus.d_misalign), 64'd0);
    chk("t4_mem_req_c2",    64'(bus.mem_req),    64'd0);

    // T5: store doubleword at 0x5000 with grant withheld for 4 cycles
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_funct3 = 3'b011;
    bus.d_addr   = 64'h5000;
    bus.d_wdata  = 64'h0123_4567_89AB_CDEF;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t5_mem_req_hold",   64'(bus.mem_req),   64'd1);
      chk("t5_mem_addr_hold",  bus.mem_addr,       64'h5000);
      chk("t5_mem_wdata_hold", bus.mem_wdata,      64'h0123_4567_89AB_CDEF);
      chk("t5_mem_wstrb_hold", 64'(bus.mem_wstrb), 64'hFF);
      chk("t5_d_valid_hold",   64'(bus.d_valid),   64'd0);
      tick();
    end
    chk("t5_mem_req_c5", 64'(bus.mem_req), 64'd1);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    tick();
    chk("t5_d_valid_c7", 64'(bus.d_valid), 64'd1);
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    tick();

    // T6: reset while waiting for the response, then a late response
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h1000;
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.if_req  = 1'b0;
    reset       = 1'b1;
    tick();
    chk("t6_mem_req_rst",  64'(bus.mem_req),  64'd0);
    chk("t6_if_valid_rst", 64'(bus.if_valid), 64'd0);
    reset          = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hFFFF_EEEE_DDDD_CCCC;
    tick();
    chk("t6_if_valid_late", 64'(bus.if_valid), 64'd0);
    chk("t6_d_valid_late",  64'(bus.d_valid),  64'd0);
    chk("t6_mem_req_late",  64'(bus.mem_req),  64'd0);
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b1;
    bus.d_we       = 1'b0;
    bus.d_funct3   = 3'b001;
    bus.d_addr     = 64'h6006;
    tick();
    chk("t6_next_mem_req",   64'(bus.mem_req),   64'd1);
    chk("t6_next_mem_addr",  bus.mem_addr,       64'h6000);
    chk("t6_next_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h8877_6655_4433_2211;
    tick();
    chk("t6_next_d_valid",    64'(bus.d_valid),    64'd1);
    chk("t6_next_d_rdata",    bus.d_rdata,         64'h8877_6655_4433_2211);
    chk("t6_next_d_misalign", 64'(bus.d_misalign), 64'd0);
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store unit of the RV64 five-stage pipeline.
- Arbitrates between the two requesters and serialises transactions, with one outstanding at a time.
- Formats write lanes/strobes and returns fetch/load data.
- Produces stall_f/stall_m, which the hazard unit ORs into StallF and StallD/FlushE.

Parameters:
XLEN, 64, data/address width; must equal the pipeline XLEN
STRB_W, XLEN/8, byte-strobe width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held high until if_valid
if_addr  in  XLEN  fetch byte address, 4-byte aligned
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held high until d_valid
d_we  in  1  1=store, 0=load
d_addr  in  XLEN  data byte address
d_wdata  in  XLEN  store data, LSB-justified
d_funct3  in  3  access size from bits [1:0]: 00 B, 01 H, 10 W, 11 D
d_rdata  out  XLEN  raw aligned doubleword; sign/zero extension is done in MEM
d_valid  out  1  one-cycle data completion pulse
d_misalign  out  1  pulses with d_valid when the access was misaligned
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  XLEN  doubleword-aligned address, low 3 bits = 0
mem_wdata  out  XLEN  lane-shifted store data
mem_wstrb  out  STRB_W  byte strobes, 0 on reads
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  response or write ack; earliest one cycle after mem_gnt
mem_rdata  in  XLEN  read data, valid with mem_rvalid
stall_f  out  1  if_req & ~if_valid, combinational
stall_m  out  1  d_req & ~d_valid, combinational

Behaviour:
- Synchronous reset. On reset:
  - state = IDLE;
  - mem_req, mem_we, mem_wstrb, if_valid, d_valid, d_misalign = 0;
  - all data/address registers = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE. The owner register (I or D) records which requester holds the current transaction.
- IDLE:
  - Requests are sampled only in IDLE.
  - d_req has strict priority over if_req when both are high.
  - On a data request, misalignment is checked first: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
    - If misaligned: next state DONE with owner D and the misalign flag set. No memory transaction is issued.
  - Otherwise the request is latched and the next state is ISSUE. Latched values:
    - address & ~7, we, owner;
    - strb: B 0x01<<a, H 0x03<<a, W 0x0F<<a, D 0xFF, where a = addr[2:0];
    - wdata = d_wdata << (8*a).
  - A fetch latches we=0, strb=0, owner=I and if_addr[2] for word select.
- ISSUE:
  - mem_req=1; mem_addr, mem_we, mem_wdata, mem_wstrb come from registers and are stable until mem_gnt.
  - On mem_gnt the next state is WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, capture mem_rdata and go to DONE. Stores also wait for mem_rvalid as an ack.
- DONE:
  - Pulse the valid of the owner for exactly one cycle, then go to IDLE.
  - if_rdata = captured[63:32] if word select=1, else captured[31:0].
  - d_rdata = captured, or 0 when misaligned; d_misalign = flag.
  - if_rdata/d_rdata hold their value until the next DONE.
- Latency (cycles from req seen in IDLE to valid): aligned = 3 + gnt wait + rvalid wait beyond the first cycle; minimum 3. Misaligned = 1.
- The requester may drop or change req in the cycle after valid. A req still high during DONE is not sampled.
- A req that drops in ISSUE/WAIT does not abort the transaction; the valid pulse is still produced.
- mem_rvalid outside WAIT is ignored.
- Reset in ISSUE/WAIT abandons the transaction: mem_req drops the next cycle and a late mem_rvalid is ignored.
- stall_f stays high while a fetch waits behind a data transaction. Fetch can be starved only by back-to-back data requests; this is accepted.

Test Plan:
- Reset, then if_req=1, if_addr=0x1004, mem_gnt=1 in ISSUE, mem_rvalid one cycle later with rdata=0xAAAA_BBBB_CCCC_DDDD -> mem_addr=0x1000, if_valid on cycle 3, if_rdata=0xAAAABBBB, stall_f high cycles 0-2.
- if_req and d_req (load, D, addr 0x2000) high in the same cycle -> data is issued first; the fetch mem_req follows after d_valid. stall_f high until the fetch completes, 7 cycles at zero wait.
- Store byte, addr 0x3005, d_wdata=0x5A -> mem_wstrb=0x20, mem_wdata=0x0000_5A00_0000_0000, mem_we=1. d_valid only after the ack.
- Load W at addr 0x4002 -> d_valid and d_misalign next cycle, d_rdata=0, no mem_req ever asserted.
- mem_gnt held low 4 cycles -> mem_req and mem_addr/wdata/wstrb stay stable; valid comes 4 cycles later than the minimum.
- reset asserted in WAIT, then mem_rvalid -> state IDLE, no valid pulse; the next request completes normally.
